// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves one GROUP-bit
// lookahead group and passes its carry, partial sum and remaining operand bits on.
module pipelined_cla_addsub #(
  parameter  int WIDTH  = 16,
  parameter  int GROUP  = 4,
  localparam int STAGES = WIDTH / GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Inter-stage registers exist only between stages; keep at least one entry.
  localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_a [PIPE];
  logic [WIDTH-1:0]  r_b [PIPE];
  logic [WIDTH-1:0]  r_s [PIPE];
  logic              r_c [PIPE];
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout, r_ovf, r_zero;

  logic [WIDTH-1:0]  w_a_nxt [PIPE];
  logic [WIDTH-1:0]  w_b_nxt [PIPE];
  logic [WIDTH-1:0]  w_s_nxt [PIPE];
  logic              w_c_nxt [PIPE];
  logic [WIDTH-1:0]  w_a_cur, w_b_cur, w_s_cur;
  logic              w_c_cur, w_msb_cin;
  logic [GROUP-1:0]  w_p, w_g;
  logic [GROUP:0]    w_cy;
  logic              w_adv;

  // Every carry is a flat sum of products of g, p and the group carry-in.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term &= p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term &= p[m];
        c[i+1] |= term;
      end
    end
    return c;
  endfunction

  assign w_adv     = ~r_vld[STAGES-1] | out_ready;
  assign in_ready  = w_adv & ~flush;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

  // NOTE: combinational logic uses blocking '=' so each stage sees the value just
  // computed for the previous one; every variable gets a default to avoid latches.
  always_comb begin
    w_a_cur   = a;
    w_b_cur   = b ^ {WIDTH{sub}};
    w_c_cur   = sub | cin;
    w_s_cur   = '0;
    w_msb_cin = 1'b0;
    w_p       = '0;
    w_g       = '0;
    w_cy      = '0;
    for (int k = 0; k < PIPE; k++) begin
      w_a_nxt[k] = '0;
      w_b_nxt[k] = '0;
      w_s_nxt[k] = '0;
      w_c_nxt[k] = 1'b0;
    end
    for (int k = 0; k < STAGES; k++) begin
      if (k > 0) begin
        w_a_cur = r_a[(k > 0) ? k - 1 : 0];
        w_b_cur = r_b[(k > 0) ? k - 1 : 0];
        w_s_cur = r_s[(k > 0) ? k - 1 : 0];
        w_c_cur = r_c[(k > 0) ? k - 1 : 0];
      end
      w_p  = w_a_cur[k*GROUP +: GROUP] ^ w_b_cur[k*GROUP +: GROUP];
      w_g  = w_a_cur[k*GROUP +: GROUP] & w_b_cur[k*GROUP +: GROUP];
      w_cy = cla_carries(w_p, w_g, w_c_cur);
      w_s_cur[k*GROUP +: GROUP] = w_p ^ w_cy[GROUP-1:0];
      if (k < STAGES - 1) begin
        w_a_nxt[k] = w_a_cur;
        w_b_nxt[k] = w_b_cur;
        w_s_nxt[k] = w_s_cur;
        w_c_nxt[k] = w_cy[GROUP];
      end else begin
        w_msb_cin = w_cy[GROUP-1];
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all stages shift together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (flush)      r_vld <= '0;
      else if (w_adv) r_vld <= (r_vld << 1) | STAGES'(in_valid);
      if (w_adv) begin
        r_sum  <= w_s_cur;
        r_cout <= w_cy[GROUP];
        r_ovf  <= w_msb_cin ^ w_cy[GROUP];
        r_zero <= ~|w_s_cur;
      end
    end
  end

  // NOTE: inter-stage data has no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        r_a[k] <= w_a_nxt[k];
        r_b[k] <= w_b_nxt[k];
        r_s[k] <= w_s_nxt[k];
        r_c[k] <= w_c_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: driver pushes expected results from
// an arithmetic model, an independent monitor pops them as results transfer out.
module tb_pipelined_cla_addsub;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int ST = W / G;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0] a, b, sum;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   epoch = 0;

  pipelined_cla_addsub #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer add/subtract with flags from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    logic [W:0] r;
    exp_t       e;
    r = '0;
    if (s) begin
      r[W-1:0] = x - y;
      e.cout   = (x >= y);
      e.ovf    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      e.cout = r[W];
      e.ovf  = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    e.sum  = r[W-1:0];
    e.zero = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts);
    bit done = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (in_ready) begin
        q.push_back(model(ta, tb_v, tc, ts));
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Monitor: transfers, handshake rule and stall stability, sampled mid-low-phase.
  initial begin : monitor
    bit   prev_stall = 0;
    int   prev_epoch = 0;
    exp_t prev_out;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      check("in_ready_rule", in_ready, !(out_valid && !out_ready) && !flush);
      if (prev_stall && prev_epoch == epoch && rst_n) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {sum, cout, ovf, zero}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.sum);
          check("cout", cout, e.cout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_epoch = epoch;
      prev_out   = {sum, cout, ovf, zero};
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    bit stop;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {sum, cout, ovf, zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors, first one also measures latency from an empty pipe.
    fork
      send(16'h1234, 16'h1111, 1'b0, 1'b0);
    join
    fork
      idle();
      begin
        lat = 0;
        #1;
        while (!out_valid && lat < 20) begin
          @(posedge clk);
          lat++;
          #1;
        end
      end
    join
    check("latency_edges", lat, ST - 1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b1);
    idle();
    drain(50);

    // Back-to-back stream with output stalled for cycles 6-9.
    fork
      begin
        for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0);
        idle();
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          out_ready = !(c >= 6 && c <= 9);
        end
      end
    join
    out_ready = 1'b1;
    drain(50);

    // Flush with three operations in flight; the flush-cycle operand is dropped.
    for (int i = 0; i < 3; i++) send(16'h0100 + W'(i), 16'h0022, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    q.delete();
    epoch++;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (ST + 1) begin
      @(posedge clk);
      #1;
      check("flush_no_out", out_valid, 0);
    end
    send(16'h4321, 16'h1234, 1'b0, 1'b1);
    fork
      idle();
      begin
        lat = 0;
        #1;
        while (!out_valid && lat < 20) begin
          @(posedge clk);
          lat++;
          #1;
        end
      end
    join
    check("flush_latency", lat, ST - 1);
    drain(50);

    // Asynchronous reset between edges with four operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(16'h0101 * W'(i), 16'h1000, 1'b0, 1'b0);
    idle();
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    q.delete();
    epoch++;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_flags", {sum, cout, ovf, zero}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    idle();
    drain(50);

    // Randomized traffic with random input gaps and random output backpressure.
    stop = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
          end
        end
        idle();
        stop = 1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
